// File: rtl/divider.sv
// divider: iterative restoring divider with a signed dividend and an unsigned
// divisor. It produces one quotient bit per clock and applies floored
// semantics, so DIV rounds toward minus infinity and MOD is non-negative.
// It uses the same stall handshake as the shift-add multiplier. The core
// holds div and the operands until stall falls, and then takes quot and rem.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset; it has priority over div
//   div    divide request, held high by the core for the whole operation
//   stall  high while a division is in progress
//   A      dividend, two's complement; sampled only in the load cycle
//   B      divisor, unsigned; sampled only in the load cycle
//   quot   quotient, two's complement
//   rem    remainder, unsigned, in [0, B)
module divider #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          div,
  output logic          stall,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  output logic [DW-1:0] quot,
  output logic [DW-1:0] rem
);

  localparam int SW = $clog2(DW + 2);
  localparam logic [SW-1:0] S_DONE = SW'(DW + 1);

  // Step counter: 0 = load, 1..DW = iterate, DW+1 = done.
  logic [SW-1:0] s_reg;
  logic [DW:0]   r_reg;
  logic [DW-1:0] q_reg;
  logic [DW-1:0] bq_reg;
  logic          neg_reg;
  logic          bz_reg;

  // Magnitude of the dividend, read as an unsigned value. The most negative
  // value maps onto itself, and that is already its correct magnitude.
  logic [DW-1:0] a_mag;
  assign a_mag = A[DW-1] ? (DW'(0) - A) : A;

  // One restoring step. Shift {R,Q} left, then try to subtract the divisor.
  // The extra top bit of diff is the borrow, and it decides the quotient bit.
  logic [DW:0]   r_sh;
  logic [DW+1:0] diff;
  logic          ge;
  logic [DW:0]   r_next;
  logic [DW-1:0] q_next;

  assign r_sh   = {r_reg[DW-1:0], q_reg[DW-1]};
  assign diff   = {1'b0, r_sh} - {2'b00, bq_reg};
  assign ge     = ~diff[DW+1];
  assign r_next = ge ? diff[DW:0] : r_sh;
  assign q_next = {q_reg[DW-2:0], ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg   <= '0;
      r_reg   <= '0;
      q_reg   <= '0;
      bq_reg  <= '0;
      neg_reg <= 1'b0;
      bz_reg  <= 1'b0;
    end else if (div) begin
      if (s_reg == '0) begin
        r_reg   <= '0;
        q_reg   <= a_mag;
        bq_reg  <= B;
        neg_reg <= A[DW-1];
        bz_reg  <= (B == '0);
        s_reg   <= SW'(1);
      end else if (s_reg != S_DONE) begin
        r_reg <= r_next;
        q_reg <= q_next;
        s_reg <= s_reg + SW'(1);
      end else begin
        // The done cycle with div still high re-arms the block, so the next
        // cycle is a load with no idle gap.
        s_reg <= '0;
      end
    end else begin
      // Dropping div abandons the operation. The datapath holds, so a
      // finished result stays visible until the next load.
      s_reg <= '0;
    end
  end

  assign stall = div & (s_reg != S_DONE);

  // Sign and floor correction of the unsigned result (q0, r0).
  logic [DW-1:0] r0;
  assign r0 = r_reg[DW-1:0];

  always_comb begin
    quot = q_reg;
    rem  = r0;
    if (bz_reg) begin
      // With a zero divisor every step subtracts nothing. Q ends as all ones
      // and R ends as |A|, so negating R gives back the captured A.
      quot = '1;
      rem  = neg_reg ? (DW'(0) - r0) : r0;
    end else if (neg_reg) begin
      if (r0 == '0) begin
        quot = DW'(0) - q_reg;
        rem  = '0;
      end else begin
        quot = ~q_reg;  // -q0 - 1
        rem  = bq_reg - r0;
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
module tb_divider;

  localparam int DW = 32;
  localparam int LAT = DW + 1;

  logic          clk;
  logic          rst;
  logic          div;
  logic          stall;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [DW-1:0] quot;
  logic [DW-1:0] rem;

  int n_cmp;
  int n_err;

  divider #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .div(div), .stall(stall),
    .A(A), .B(B), .quot(quot), .rem(rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Floored division computed with plain wide signed arithmetic.
  function automatic void ref_div(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  output logic [DW-1:0] q, output logic [DW-1:0] r);
    longint sa, ub, lq, lr;
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      sa = longint'($signed(a));
      ub = longint'({32'd0, b});
      lq = sa / ub;
      lr = sa % ub;
      if (lr < 0) begin
        lq = lq - 1;
        lr = lr + ub;
      end
      q = lq[DW-1:0];
      r = lr[DW-1:0];
    end
  endfunction

  // Counts stall cycles from the current cycle until stall falls, then
  // samples the results in the done cycle. When perturb_at is nonzero, the
  // operands are scrambled after that many stall cycles.
  task automatic run_op(input int perturb_at, output int cnt,
                        output logic [DW-1:0] q, output logic [DW-1:0] r);
    cnt = 0;
    for (int i = 0; i < 3 * LAT; i++) begin
      @(negedge clk);
      if (!stall) break;
      cnt++;
      if (perturb_at != 0 && cnt == perturb_at) begin
        A = $urandom;
        B = $urandom;
      end
    end
    q = quot;
    r = rem;
  endtask

  task automatic start(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(posedge clk);
    #1;
    A = a;
    B = b;
    div = 1'b1;
  endtask

  task automatic finish_op();
    @(posedge clk);
    #1;
    div = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    div = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %0b want 0", stall); end
    n_cmp++;
    if (quot !== '0) begin n_err++; $display("FAIL reset_quot got %h want 0", quot); end
    n_cmp++;
    if (rem !== '0) begin n_err++; $display("FAIL reset_rem got %h want 0", rem); end
    $display("txn reset stall=%0b quot=%h rem=%h", stall, quot, rem);
  endtask

  // Directed operand pairs, including the boundary cases.
  task automatic test_directed();
    logic [DW-1:0] ta[8];
    logic [DW-1:0] tb_[8];
    logic [DW-1:0] q, r, eq, er;
    int cnt;
    ta[0] = 32'd100;      tb_[0] = 32'd7;
    ta[1] = 32'hFFFFFFF9; tb_[1] = 32'd2;
    ta[2] = 32'hFFFFFFF8; tb_[2] = 32'd2;
    ta[3] = 32'd5;        tb_[3] = 32'd0;
    ta[4] = 32'h80000000; tb_[4] = 32'd1;
    ta[5] = 32'hFFFFFFFF; tb_[5] = 32'hFFFFFFFF;
    ta[6] = 32'h7FFFFFFF; tb_[6] = 32'h80000000;
    ta[7] = 32'hFFFFFFFB; tb_[7] = 32'd0;
    for (int i = 0; i < 8; i++) begin
      ref_div(ta[i], tb_[i], eq, er);
      start(ta[i], tb_[i]);
      run_op(0, cnt, q, r);
      n_cmp++;
      if (cnt !== LAT) begin n_err++; $display("FAIL dir%0d_stall got %0d want %0d", i, cnt, LAT); end
      n_cmp++;
      if (q !== eq) begin n_err++; $display("FAIL dir%0d_quot got %h want %h", i, q, eq); end
      n_cmp++;
      if (r !== er) begin n_err++; $display("FAIL dir%0d_rem got %h want %h", i, r, er); end
      $display("txn directed A=%h B=%h quot=%h rem=%h stall_cycles=%0d", ta[i], tb_[i], q, r, cnt);
      finish_op();
      // Results must persist after div falls.
      @(negedge clk);
      n_cmp++;
      if (quot !== eq || rem !== er) begin
        n_err++;
        $display("FAIL dir%0d_hold got %h/%h want %h/%h", i, quot, rem, eq, er);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] q, r;
    int cnt;
    start(32'd100, 32'd7);
    run_op(7, cnt, q, r);  // scrambling the operands mid-operation must not matter
    n_cmp++;
    if (q !== 32'd14 || r !== 32'd2) begin
      n_err++;
      $display("FAIL b2b_first got %h/%h want 0000000e/00000002", q, r);
    end
    $display("txn b2b first quot=%h rem=%h", q, r);
    // Keep div high and switch the operands right after the done cycle.
    @(posedge clk);
    #1;
    A = 32'd45;
    B = 32'd9;
    run_op(0, cnt, q, r);
    n_cmp++;
    if (cnt !== LAT) begin n_err++; $display("FAIL b2b_stall got %0d want %0d", cnt, LAT); end
    n_cmp++;
    if (q !== 32'd5 || r !== 32'd0) begin
      n_err++;
      $display("FAIL b2b_second got %h/%h want 00000005/00000000", q, r);
    end
    $display("txn b2b second quot=%h rem=%h stall_cycles=%0d", q, r, cnt);
    finish_op();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] q, r;
    int cnt;
    start(32'hFFFFFF9C, 32'd7);  // -100 / 7
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(0, cnt, q, r);
    n_cmp++;
    if (cnt !== LAT) begin n_err++; $display("FAIL rstmid_stall got %0d want %0d", cnt, LAT); end
    n_cmp++;
    if (q !== 32'hFFFFFFF1 || r !== 32'd5) begin
      n_err++;
      $display("FAIL rstmid_result got %h/%h want fffffff1/00000005", q, r);
    end
    $display("txn reset_mid quot=%h rem=%h stall_cycles=%0d", q, r, cnt);
    finish_op();
  endtask

  task automatic test_abort();
    logic [DW-1:0] q, r;
    int cnt;
    start(32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    div = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL abort_stall got %0b want 0", stall); end
    start(32'd1000, 32'd3);
    run_op(0, cnt, q, r);
    n_cmp++;
    if (cnt !== LAT || q !== 32'd333 || r !== 32'd1) begin
      n_err++;
      $display("FAIL abort_restart got %0d %h/%h want %0d 0000014d/00000001", cnt, q, r, LAT);
    end
    $display("txn abort_restart quot=%h rem=%h stall_cycles=%0d", q, r, cnt);
    finish_op();
  endtask

  task automatic test_random();
    logic [DW-1:0] a, b, q, r, eq, er;
    int cnt;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = DW'($urandom_range(1, 20));
        2: b = '0;
        3: b = DW'($urandom_range(1, 65535));
        default: begin b = $urandom; a = {1'b1, 31'($urandom_range(0, 15))}; end
      endcase
      ref_div(a, b, eq, er);
      start(a, b);
      run_op(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : 0, cnt, q, r);
      n_cmp++;
      if (cnt !== LAT || q !== eq || r !== er) begin
        n_err++;
        $display("FAIL rand%0d A=%h B=%h got %0d %h/%h want %0d %h/%h",
                 i, a, b, cnt, q, r, LAT, eq, er);
      end
      $display("txn random A=%h B=%h quot=%h rem=%h", a, b, q, r);
      finish_op();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    div = 1'b0;
    A = '0;
    B = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
